reg_file_np: RTL and testbench



---
 rtl/reg_file_np.sv | 97 +++++++++
 tb/tb_reg_file_np.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/reg_file_np.sv
// rtl/reg_file_np.sv - multi-entry negative-edge register file, byte-masked write, two async reads
//
// Purpose:
//   DEPTH words of WIDTH bits. One write port commits on the falling edge of
//   clk, so a value written in the second half of a cycle is visible at the
//   next rising edge. Two independent, purely combinational read ports.
//   Asynchronous active-low clear loads RESET_VAL into every word.
//
// Ports:
//   clk      in   clock; storage updates on falling edge only
//   rst_n    in   asynchronous active-low reset
//   we       in   write enable, sampled at falling edge
//   waddr    in   [ADDR_W]   write address
//   wdata    in   [WIDTH]    write data
//   wbe      in   [WIDTH/8]  byte write enables, bit k covers wdata[8k+7:8k]
//   raddr_a  in   [ADDR_W]   read port A address
//   rdata_a  out  [WIDTH]    read port A data (zero when address >= DEPTH)
//   raddr_b  in   [ADDR_W]   read port B address
//   rdata_b  out  [WIDTH]    read port B data (zero when address >= DEPTH)
//
// Optional feature:
//   REG_FILE_ZERO_REG_EN - word 0 is hardwired to zero: no storage, writes
//   to it are discarded and reads of address 0 always return zero.

`timescale 1ns/1ps

module reg_file_np #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 32,
  parameter int               ADDR_W    = 5,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [WIDTH/8-1:0]   wbe,
  input  logic [ADDR_W-1:0]    raddr_a,
  output logic [WIDTH-1:0]     rdata_a,
  input  logic [ADDR_W-1:0]    raddr_b,
  output logic [WIDTH-1:0]     rdata_b
);

  localparam int NB = WIDTH / 8;

`ifdef REG_FILE_ZERO_REG_EN
  // Word 0 is a constant, so storage starts at index 1.
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif

  logic [WIDTH-1:0] words [FIRST:DEPTH-1];

  // Write decode compares against each implemented index only, so an
  // out-of-range address matches no word and cannot alias onto one.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = FIRST; i < DEPTH; i++) begin
        words[i] <= RESET_VAL;
      end
    end else if (we) begin
      for (int i = FIRST; i < DEPTH; i++) begin
        if (waddr == ADDR_W'(i)) begin
          for (int b = 0; b < NB; b++) begin
            if (wbe[b]) begin
              words[i][8*b +: 8] <= wdata[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // Unmatched addresses (out of range, or the hardwired zero word) fall
  // through to the all-zero default. No write bypass: reads see the stored
  // value until the falling edge commits the new one.
  always_comb begin
    rdata_a = '0;
    for (int i = FIRST; i < DEPTH; i++) begin
      if (raddr_a == ADDR_W'(i)) begin
        rdata_a = words[i];
      end
    end
  end

  always_comb begin
    rdata_b = '0;
    for (int i = FIRST; i < DEPTH; i++) begin
      if (raddr_b == ADDR_W'(i)) begin
        rdata_b = words[i];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_np.sv
// tb/tb_reg_file_np.sv - directed table-driven bench for reg_file_np

`timescale 1ns/1ps

module tb_reg_file_np;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 24;
  localparam int ADDR_W = 5;

`ifdef REG_FILE_ZERO_REG_EN
  localparam logic [31:0] W0_EXP = 32'h0000_0000;
`else
  localparam logic [31:0] W0_EXP = 32'hCAFE_F00D;
`endif

  logic              clk;
  logic              rst_n;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic [3:0]        wbe;
  logic [ADDR_W-1:0] raddr_a;
  logic [WIDTH-1:0]  rdata_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [WIDTH-1:0]  rdata_b;

  int n_tests;
  int n_fail;

  reg_file_np #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .RESET_VAL(32'h0)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .wbe    (wbe),
    .raddr_a(raddr_a),
    .rdata_a(rdata_a),
    .raddr_b(raddr_b),
    .rdata_b(rdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic [3:0]        wbe;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
    logic [31:0]       exp_a;
    logic [31:0]       exp_b;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive just after a rising edge, so the write commits at the next falling edge.
  task automatic drive(input logic w, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb);
    @(posedge clk);
    #1;
    we = w; waddr = a; wdata = d; wbe = be; raddr_a = ra; raddr_b = rb;
  endtask

  task automatic after_negedge();
    @(negedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    we = 1'b0; waddr = '0; wdata = '0; wbe = '0; raddr_a = '0; raddr_b = '0;

    //                 we    waddr  wdata          wbe      ra  rb  exp_a          exp_b
    vecs[0]  = '{1'b1, 5'd1,  32'h1111_1111, 4'hF,    5'd1,  5'd2,  32'h1111_1111, 32'h0};
    vecs[1]  = '{1'b1, 5'd2,  32'hA5A5_A5A5, 4'hF,    5'd1,  5'd2,  32'h1111_1111, 32'hA5A5_A5A5};
    vecs[2]  = '{1'b0, 5'd1,  32'hFFFF_FFFF, 4'hF,    5'd1,  5'd2,  32'h1111_1111, 32'hA5A5_A5A5};
    vecs[3]  = '{1'b1, 5'd5,  32'hAABB_CCDD, 4'hF,    5'd5,  5'd5,  32'hAABB_CCDD, 32'hAABB_CCDD};
    vecs[4]  = '{1'b1, 5'd5,  32'h1122_3344, 4'b0101, 5'd5,  5'd5,  32'hAA22_CC44, 32'hAA22_CC44};
    vecs[5]  = '{1'b1, 5'd5,  32'h0000_0000, 4'b0000, 5'd5,  5'd5,  32'hAA22_CC44, 32'hAA22_CC44};
    vecs[6]  = '{1'b1, 5'd23, 32'hDEAD_BEEF, 4'hF,    5'd23, 5'd24, 32'hDEAD_BEEF, 32'h0};
    vecs[7]  = '{1'b1, 5'd6,  32'h0000_0066, 4'hF,    5'd6,  5'd14, 32'h0000_0066, 32'h0};
    vecs[8]  = '{1'b1, 5'd14, 32'h0E0E_0E0E, 4'hF,    5'd14, 5'd6,  32'h0E0E_0E0E, 32'h0000_0066};
    vecs[9]  = '{1'b1, 5'd30, 32'hFFFF_FFFF, 4'hF,    5'd6,  5'd14, 32'h0000_0066, 32'h0E0E_0E0E};
    vecs[10] = '{1'b1, 5'd24, 32'hFFFF_FFFF, 4'hF,    5'd8,  5'd30, 32'h0,         32'h0};
    vecs[11] = '{1'b1, 5'd0,  32'hCAFE_F00D, 4'hF,    5'd0,  5'd23, W0_EXP,        32'hDEAD_BEEF};
    vecs[12] = '{1'b1, 5'd7,  32'h7800_0012, 4'b1000, 5'd7,  5'd0,  32'h7800_0000, W0_EXP};

    // Reset state, then asynchronous release between edges.
    #2;
    raddr_a = 5'd1; raddr_b = 5'd23;
    #1;
    check("reset_a", rdata_a, 32'h0);
    check("reset_b", rdata_b, 32'h0);
    #9;
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].wbe, vecs[i].ra, vecs[i].rb);
      after_negedge();
      check($sformatf("vec%0d_a", i), rdata_a, vecs[i].exp_a);
      check($sformatf("vec%0d_b", i), rdata_b, vecs[i].exp_b);
    end

    // Negedge commit: old value visible until the falling edge.
    drive(1'b1, 5'd3, 32'h1234_5678, 4'hF, 5'd3, 5'd3);
    #1;
    check("commit_pre", rdata_a, 32'h0);
    after_negedge();
    check("commit_post", rdata_a, 32'h1234_5678);

    // Dual read of the word being written.
    drive(1'b1, 5'd9, 32'h5555_5555, 4'hF, 5'd9, 5'd9);
    after_negedge();
    drive(1'b1, 5'd9, 32'h0F0F_0F0F, 4'hF, 5'd9, 5'd9);
    #1;
    check("dual_pre_a", rdata_a, 32'h5555_5555);
    check("dual_pre_b", rdata_b, 32'h5555_5555);
    after_negedge();
    check("dual_post_a", rdata_a, 32'h0F0F_0F0F);
    check("dual_post_b", rdata_b, 32'h0F0F_0F0F);
    drive(1'b0, 5'd9, 32'hFFFF_FFFF, 4'hF, 5'd9, 5'd9);
    after_negedge();
    check("dual_hold_a", rdata_a, 32'h0F0F_0F0F);
    check("dual_hold_b", rdata_b, 32'h0F0F_0F0F);

    // Asynchronous clear mid-high-phase, with a write held off across a falling edge.
    drive(1'b1, 5'd7, 32'hDEAD_BEEF, 4'hF, 5'd7, 5'd5);
    after_negedge();
    check("clr_setup", rdata_a, 32'hDEAD_BEEF);
    drive(1'b1, 5'd7, 32'h0000_0001, 4'hF, 5'd7, 5'd5);
    rst_n = 1'b0;
    #1;
    check("clr_async_a", rdata_a, 32'h0);
    check("clr_async_b", rdata_b, 32'h0);
    after_negedge();
    check("clr_no_write", rdata_a, 32'h0);
    @(posedge clk);
    #1;
    we = 1'b0;
    rst_n = 1'b1;
    after_negedge();
    check("clr_released", rdata_a, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
